// File: rtl/regfile_ctrl.sv
// regfile_ctrl: command-driven initiator for an 8 x 16 register file.
// Executes LOAD / MOV / SWAP / DUMP by driving the register file's read and
// write ports. DUMP streams every register out over a second channel.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The command channel is ready only in IDLE. The dump channel holds
// dump_valid and its payload stable until dump_ready is seen.
module regfile_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] rf_data_in,
  output logic [ADDR_W-1:0] rf_writenum,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_readnum,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_idx,
  output logic              dump_last,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_XW   = 3'd2,
    S_WR   = 3'd3,
    S_DUMP = 3'd4
  } state_t;

  localparam logic [1:0]        OP_LOAD = 2'b00;
  localparam logic [1:0]        OP_MOV  = 2'b01;
  localparam logic [1:0]        OP_SWAP = 2'b10;
  localparam logic [1:0]        OP_DUMP = 2'b11;
  localparam logic [ADDR_W-1:0] IDX_MAX = '1;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [ADDR_W-1:0]   rs_q, rs_d;
  logic [DATA_W-1:0]   tmp_q, tmp_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;

  // State and command registers; reset returns to IDLE immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      rd_q    <= '0;
      rs_q    <= '0;
      tmp_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      tmp_q   <= tmp_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and outputs. Register-file outputs depend only on state and
  // latched fields, never on cmd_*, so no command-to-regfile comb path exists.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rs_d        = rs_q;
    tmp_d       = tmp_q;
    idx_d       = idx_q;
    cmd_ready   = 1'b0;
    rf_write    = 1'b0;
    rf_writenum = '0;
    rf_readnum  = '0;
    rf_data_in  = '0;
    dump_valid  = 1'b0;
    dump_data   = '0;
    dump_idx    = '0;
    dump_last   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d  = cmd_op;
          rd_d  = cmd_rd;
          rs_d  = cmd_rs;
          tmp_d = cmd_imm;
          idx_d = '0;
          case (cmd_op)
            OP_LOAD: state_d = S_WR;
            OP_MOV:  state_d = S_RD;
            OP_SWAP: state_d = S_RD;
            default: state_d = S_DUMP;
          endcase
        end
      end
      S_RD: begin
        // Capture reg[rs]; SWAP needs an extra cycle to move reg[rd] into rs.
        rf_readnum = rs_q;
        tmp_d      = rf_data_out;
        state_d    = (op_q == OP_SWAP) ? S_XW : S_WR;
      end
      S_XW: begin
        // Read reg[rd] and write it straight into reg[rs] in the same cycle.
        rf_readnum  = rd_q;
        rf_writenum = rs_q;
        rf_write    = 1'b1;
        rf_data_in  = rf_data_out;
        state_d     = S_WR;
      end
      S_WR: begin
        rf_write    = 1'b1;
        rf_writenum = rd_q;
        rf_data_in  = tmp_q;
        state_d     = S_IDLE;
      end
      S_DUMP: begin
        // No writes here, so the read data stays stable during a stall.
        rf_readnum = idx_q;
        dump_valid = 1'b1;
        dump_data  = rf_data_out;
        dump_idx   = idx_q;
        dump_last  = (idx_q == IDX_MAX);
        if (dump_ready) begin
          if (idx_q == IDX_MAX) state_d = S_IDLE;
          else                  idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: the register file is modelled here, and a
// command-level reference array predicts its contents and the dump stream.
module tb_regfile_ctrl;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NREG = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_rd = '0;
  logic [AW-1:0] cmd_rs = '0;
  logic [DW-1:0] cmd_imm = '0;
  logic [DW-1:0] rf_data_in;
  logic [AW-1:0] rf_writenum;
  logic          rf_write;
  logic [AW-1:0] rf_readnum;
  logic [DW-1:0] rf_data_out;
  logic          dump_valid;
  logic          dump_ready = 1'b0;
  logic [DW-1:0] dump_data;
  logic [AW-1:0] dump_idx;
  logic          dump_last;
  logic          busy;
  logic [2:0]    dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  regfile_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
    .rf_data_in(rf_data_in), .rf_writenum(rf_writenum), .rf_write(rf_write),
    .rf_readnum(rf_readnum), .rf_data_out(rf_data_out),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_idx(dump_idx), .dump_last(dump_last), .busy(busy), .dbg_state(dbg_state)
  );

  // register file: combinational read, synchronous write
  logic [DW-1:0] rf_mem [NREG];
  int            wr_count = 0;
  logic [AW-1:0] last_wnum = '0;
  assign rf_data_out = rf_mem[rf_readnum];

  always @(posedge clk) begin
    if (rf_write) begin
      rf_mem[rf_writenum] <= rf_data_in;
      wr_count  <= wr_count + 1;
      last_wnum <= rf_writenum;
    end
  end

  // reference model and scoreboard
  logic [DW-1:0] ref_mem [NREG];
  logic [DW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < NREG; i++) check(tag, {16'h0, rf_mem[i]}, {16'h0, ref_mem[i]});
  endtask

  // high-level effect of one command on the register array
  task automatic model_cmd(input logic [1:0] op, input int rd, input int rs);
    logic [DW-1:0] t;
    case (op)
      2'b00: ref_mem[rd] = cmd_imm;
      2'b01: ref_mem[rd] = ref_mem[rs];
      2'b10: begin t = ref_mem[rs]; ref_mem[rs] = ref_mem[rd]; ref_mem[rd] = t; end
      default: for (int i = 0; i < NREG; i++) exp_q.push_back(ref_mem[i]);
    endcase
  endtask

  // drive one command, follow it to completion, check latency/writes/dump/mem
  task automatic run_cmd(input logic [1:0] op, input int rd, input int rs,
                         input logic [DW-1:0] imm, input bit toggle);
    int lat_exp, wr_exp, w0, cyc, beat;
    bit stalled;
    logic [DW-1:0] s_data;
    logic [AW-1:0] s_idx;
    logic          s_last;
    logic [DW-1:0] e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = AW'(rd); cmd_rs = AW'(rs); cmd_imm = imm;
    check("ready_before_cmd", {31'h0, cmd_ready}, 32'h1);
    model_cmd(op, rd, rs);
    case (op)
      2'b00: begin lat_exp = 1; wr_exp = 1; end
      2'b01: begin lat_exp = 2; wr_exp = 1; end
      2'b10: begin lat_exp = 3; wr_exp = 2; end
      default: begin lat_exp = toggle ? 16 : 8; wr_exp = 0; end
    endcase
    w0 = wr_count;
    dump_ready = toggle ? 1'b0 : 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 0; beat = 0; stalled = 0;
    s_data = '0; s_idx = '0; s_last = 1'b0;
    while (busy && cyc < 200) begin
      cyc++;
      if (op == 2'b11) begin
        if (toggle) dump_ready = ~cyc[0];
        check("dump_valid", {31'h0, dump_valid}, 32'h1);
        check("dump_no_write", {31'h0, rf_write}, 32'h0);
        if (stalled) begin
          check("stall_data", {16'h0, dump_data}, {16'h0, s_data});
          check("stall_idx", {29'h0, dump_idx}, {29'h0, s_idx});
          check("stall_last", {31'h0, dump_last}, {31'h0, s_last});
        end
        if (dump_ready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
          check("dump_data", {16'h0, dump_data}, {16'h0, e});
          check("dump_idx", {29'h0, dump_idx}, 32'(beat));
          check("dump_last", {31'h0, dump_last}, {31'h0, beat == NREG - 1});
          beat++;
          stalled = 0;
        end else begin
          stalled = 1;
          s_data = dump_data; s_idx = dump_idx; s_last = dump_last;
        end
      end
      @(negedge clk);
    end
    dump_ready = 1'b0;
    check("busy_cycles", 32'(cyc), 32'(lat_exp));
    check("write_count", 32'(wr_count - w0), 32'(wr_exp));
    check("ready_after", {31'h0, cmd_ready}, 32'h1);
    if (op == 2'b11) begin
      check("dump_beats", 32'(beat), 32'(NREG));
      check("dump_q_empty", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
    end else begin
      check("last_writenum", {29'h0, last_wnum}, 32'(rd));
    end
    check_mem("mem");
  endtask

  initial begin
    int accepts, w0, guard;
    logic [DW-1:0] vals [NREG];
    vals = '{16'h53DD, 16'h5DDD, 16'h53EF, 16'h4B5D, 16'h5ACA, 16'hADDD, 16'h6A95, 16'hAA95};
    for (int i = 0; i < NREG; i++) begin
      rf_mem[i]  = 16'($urandom);
      ref_mem[i] = rf_mem[i];
    end

    // reset values
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_rf_write", {31'h0, rf_write}, 32'h0);
    check("rst_writenum", {29'h0, rf_writenum}, 32'h0);
    check("rst_readnum", {29'h0, rf_readnum}, 32'h0);
    check("rst_data_in", {16'h0, rf_data_in}, 32'h0);
    check("rst_dump_valid", {31'h0, dump_valid}, 32'h0);
    check("rst_dump_idx", {29'h0, dump_idx}, 32'h0);
    check("rst_dump_last", {31'h0, dump_last}, 32'h0);
    reset_n = 1'b1;

    // directed sequence
    run_cmd(2'b00, 3, 0, 16'h53DD, 0);
    run_cmd(2'b00, 0, 0, 16'h53DD, 0);
    run_cmd(2'b00, 7, 0, 16'hAA95, 0);
    run_cmd(2'b00, 3, 0, 16'h4B5D, 0);
    run_cmd(2'b01, 5, 3, 16'h0000, 0);
    run_cmd(2'b10, 0, 7, 16'h0000, 0);
    run_cmd(2'b10, 2, 2, 16'h0000, 0);
    run_cmd(2'b01, 6, 6, 16'h0000, 0);
    for (int i = 0; i < NREG; i++) run_cmd(2'b00, i, 0, vals[i], 0);
    run_cmd(2'b11, 0, 0, 16'h0000, 1);
    run_cmd(2'b11, 0, 0, 16'h0000, 0);

    // reset during the WR cycle of SWAP rd=1 rs=4
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_rd = 3'd1; cmd_rs = 3'd4;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("xw_write", {31'h0, rf_write}, 32'h1);
    @(negedge clk);
    check("wr_write", {31'h0, rf_write}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("rst_async_write", {31'h0, rf_write}, 32'h0);
    check("rst_async_ready", {31'h0, cmd_ready}, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    ref_mem[4] = ref_mem[1];
    @(negedge clk);
    check("ready_post_rst", {31'h0, cmd_ready}, 32'h1);
    check_mem("mem_swap_rst");
    run_cmd(2'b00, 2, 0, 16'h1234, 0);

    // cmd_valid held high for 5 cycles with a LOAD
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rd = 3'd6; cmd_imm = 16'hBEEF;
    accepts = 0; w0 = wr_count;
    for (int i = 0; i < 5; i++) begin
      check("busy_eq_not_ready", {31'h0, busy}, {31'h0, ~cmd_ready});
      if (cmd_ready) accepts++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    guard = 0;
    while (busy && guard < 20) begin guard++; @(negedge clk); end
    ref_mem[6] = 16'hBEEF;
    check("hold_accepts", 32'(accepts), 32'h3);
    check("hold_writes", 32'(wr_count - w0), 32'(accepts));
    check_mem("mem_hold");

    // randomized commands
    for (int n = 0; n < 40; n++) begin
      run_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 7),
              16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
